// File: rtl/vm_pkg.sv
// vm_pkg: coin codes and transmit FSM encoding
// shared by the vending-machine coin front end.
package vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1    = 2'd1;
  localparam logic [1:0] COIN_2    = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-flop synchronizer, debounce counter and rising-edge strobe.
// Ports: clk, rst_n, sense (raw async line), rise (one-cycle event on debounced 0->1).
module coin_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sense,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYC);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          sync;

  assign sync = sync_q[1];

  // Once the mismatch has lasted CMAX cycles the level flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sense};
      rise   <= 1'b0;
      if (cnt_q == CMAX) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
        rise    <= ~level_q;
      end else if (sync != level_q) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounced coin slots -> FIFO -> paced 2-bit coin bus.
// Ports: clk, rst_n, sense1/sense2 (raw), vend_busy; coin, reject_code, fifo_full, pending.
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int GAP_CYC      = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sense1,
  input  logic                        sense2,
  input  logic                        vend_busy,
  output logic [1:0]                  coin,
  output logic [1:0]                  reject_code,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYC - 1);

  logic          rise1;
  logic          rise2;
  logic          hold_q;
  logic          hold_d;
  logic [1:0]    ev_code;
  logic          ev;
  logic          push;
  logic          pop;
  logic          can_pop;
  logic [1:0]    reject_d;
  logic [1:0]    coin_d;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [PW-1:0] cnt_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  tx_state_t     state_q;
  tx_state_t     state_d;

  coin_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db1 (
    .clk  (clk),
    .rst_n(rst_n),
    .sense(sense1),
    .rise (rise1)
  );

  coin_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db2 (
    .clk  (clk),
    .rst_n(rst_n),
    .sense(sense2),
    .rise (rise2)
  );

  // Held 2-unit coin from a simultaneous pair goes first.
  always_comb begin
    ev_code = COIN_NONE;
    if (hold_q)     ev_code = COIN_2;
    else if (rise1) ev_code = COIN_1;
    else if (rise2) ev_code = COIN_2;
  end

  assign ev     = (ev_code != COIN_NONE);
  assign hold_d = !hold_q && rise1 && rise2;
  assign push   = ev && !vend_busy && !fifo_full;

  always_comb begin
    reject_d = COIN_NONE;
    if (ev && !push) reject_d = ev_code;
  end

  assign can_pop = (pending != '0) && !vend_busy;

  // Last GAP cycle may launch the next code directly.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = GAP;
        gap_d   = '0;
      end
      GAP: begin
        if (gap_q == GLAST) begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coin_d = COIN_NONE;
    if (pop) coin_d = mem[rd_q];
  end

  always_comb begin
    cnt_d = pending;
    if (push && !pop)      cnt_d = pending + PW'(1);
    else if (pop && !push) cnt_d = pending - PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      hold_q      <= 1'b0;
      coin        <= COIN_NONE;
      reject_code <= COIN_NONE;
      fifo_full   <= 1'b0;
      pending     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= COIN_NONE;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      hold_q      <= hold_d;
      coin        <= coin_d;
      reject_code <= reject_d;
      pending     <= cnt_d;
      fifo_full   <= (cnt_d == PW'(FIFO_DEPTH));
      if (push) begin
        mem[wr_q] <= ev_code;
        wr_q      <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

endmodule
